// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// One product or quotient bit per cycle, plus MTHI/MTLO writes.
module mips_muldiv_unit #(
  parameter int BITS        = 32,
  parameter int OPTION_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OPTION_BITS-1:0] select,
  input  logic [BITS-1:0]        a,
  input  logic [BITS-1:0]        b,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero,
  output logic [BITS-1:0]        hi,
  output logic [BITS-1:0]        lo
);

  localparam int CW = $clog2(BITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [OPTION_BITS-1:0] OP_MULT  = OPTION_BITS'(8'h18);
  localparam logic [OPTION_BITS-1:0] OP_MULTU = OPTION_BITS'(8'h19);
  localparam logic [OPTION_BITS-1:0] OP_DIV   = OPTION_BITS'(8'h1A);
  localparam logic [OPTION_BITS-1:0] OP_DIVU  = OPTION_BITS'(8'h1B);
  localparam logic [OPTION_BITS-1:0] OP_MTHI  = OPTION_BITS'(8'h11);
  localparam logic [OPTION_BITS-1:0] OP_MTLO  = OPTION_BITS'(8'h13);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*BITS-1:0] acc;
  logic [BITS-1:0]   opd;
  logic              sign_a;
  logic              sign_b;
  logic              is_mul;

  logic              accept;
  logic              op_mult;
  logic              op_multu;
  logic              op_div;
  logic              op_divu;
  logic              op_mthi;
  logic              op_mtlo;
  logic              op_signed;
  logic              op_muls;
  logic              op_divs;
  logic              div_zero;
  logic [BITS-1:0]   abs_a;
  logic [BITS-1:0]   abs_b;

  logic [BITS:0]     mul_sum;
  logic [2*BITS-1:0] mul_next;
  logic [BITS:0]     div_rs;
  logic              div_ge;
  logic [BITS-1:0]   div_diff;
  logic [2*BITS-1:0] div_next;
  logic              last;

  logic [2*BITS-1:0] prod;
  logic [BITS-1:0]   quo;
  logic [BITS-1:0]   rem;

  // Operation decode; a start is only taken in IDLE outside the done cycle.
  always_comb begin
    op_mult   = (select == OP_MULT);
    op_multu  = (select == OP_MULTU);
    op_div    = (select == OP_DIV);
    op_divu   = (select == OP_DIVU);
    op_mthi   = (select == OP_MTHI);
    op_mtlo   = (select == OP_MTLO);
    op_signed = op_mult | op_div;
    op_muls   = op_mult | op_multu;
    op_divs   = op_div | op_divu;
    div_zero  = op_divs & (b == '0);
    accept    = (state == S_IDLE) & start & ~done;
    abs_a     = (op_signed & a[BITS-1]) ? (~a + 1'b1) : a;
    abs_b     = (op_signed & b[BITS-1]) ? (~b + 1'b1) : b;
  end

  // One shift-add step and one restoring-divide step on the accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc[2*BITS-1:BITS]} + {1'b0, opd};
    mul_next = acc[0] ? {mul_sum, acc[BITS-1:1]}
                      : {1'b0, acc[2*BITS-1:1]};
    div_rs   = acc[2*BITS-1:BITS-1];
    div_ge   = (div_rs >= {1'b0, opd});
    div_diff = div_rs[BITS-1:0] - opd;
    div_next = {(div_ge ? div_diff : div_rs[BITS-1:0]),
                acc[BITS-2:0], div_ge};
    last     = (cnt == CW'(1));
  end

  // Sign fix-up of the finished product, quotient and remainder.
  always_comb begin
    prod = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo  = (sign_a ^ sign_b) ? (~acc[BITS-1:0] + 1'b1)
                             : acc[BITS-1:0];
    rem  = sign_a ? (~acc[2*BITS-1:BITS] + 1'b1)
                  : acc[2*BITS-1:BITS];
  end

  // Control FSM: state, iteration counter and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_mthi | op_mtlo) begin
              done <= 1'b1;
            end else if (div_zero) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else if (op_muls | op_divs) begin
              cnt   <= CW'(BITS);
              busy  <= 1'b1;
              state <= op_muls ? S_MUL : S_DIV;
            end
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt - 1'b1;
          if (last) state <= S_FIX;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Operand latch and per-cycle accumulator update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opd    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_mul <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept & ~div_zero & (op_muls | op_divs)) begin
            sign_a <= op_signed & a[BITS-1];
            sign_b <= op_signed & b[BITS-1];
            is_mul <= op_muls;
            if (op_muls) begin
              acc <= {{BITS{1'b0}}, abs_b};
              opd <= abs_a;
            end else begin
              acc <= {{BITS{1'b0}}, abs_a};
              opd <= abs_b;
            end
          end
        end
        S_MUL:   acc <= mul_next;
        S_DIV:   acc <= div_next;
        default: acc <= acc;
      endcase
    end
  end

  // HI/LO change only on MTHI/MTLO, divide-by-zero or the FIX cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (accept & op_mthi) begin
      hi <= a;
    end else if (accept & op_mtlo) begin
      lo <= a;
    end else if (accept & div_zero) begin
      hi <= a;
      lo <= '1;
    end else if (state == S_FIX) begin
      if (is_mul) begin
        hi <= prod[2*BITS-1:BITS];
        lo <= prod[BITS-1:0];
      end else begin
        hi <= rem;
        lo <= quo;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit: vector table with a result
// scoreboard plus hand sequences for busy, reset and bad opcodes.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  select;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  vec_t tbl[13];
  exp_t sbq[$];

  mips_muldiv_unit #(.BITS(32), .OPTION_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .select(select),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Issue one op, wait for done, compare against the scoreboard head.
  // inj > 0 re-asserts start with a DIV at that edge while busy.
  task automatic run_op(input string nm, input logic [7:0] s,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input exp_t e, input int inj);
    int edges;
    int bcyc;
    int chg;
    logic [31:0] h0;
    logic [31:0] l0;
    exp_t x;
    sbq.push_back(e);
    @(negedge clk);
    h0 = hi;
    l0 = lo;
    start = 1'b1;
    select = s;
    a = ia;
    b = ib;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    bcyc = 0;
    chg = 0;
    while (!done && edges < 100) begin
      if (busy) begin
        bcyc++;
        if (hi !== h0 || lo !== l0) chg++;
      end
      if (inj > 0 && edges == inj) begin
        start = 1'b1;
        select = 8'h1A;
        a = 32'd100;
        b = 32'd3;
      end else if (inj > 0 && edges == inj + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      #1;
    end
    x = sbq.pop_front();
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done after %0d edges", nm, edges);
    end else begin
      check({nm, " hi"}, 64'(hi), 64'(x.hi));
      check({nm, " lo"}, 64'(lo), 64'(x.lo));
      check({nm, " dbz"}, 64'(div_by_zero), 64'(x.dbz));
      check({nm, " latency"}, 64'(edges - 1), 64'(x.lat));
      check({nm, " busy cycles"}, 64'(bcyc), 64'(x.lat));
      check({nm, " busy at done"}, 64'(busy), 64'(0));
      check({nm, " hi/lo held"}, 64'(chg), 64'(0));
    end
    @(posedge clk);
    #1;
    check({nm, " done pulse"}, 64'(done), 64'(0));
  endtask

  // Watch n cycles and count done and busy samples.
  task automatic idle_watch(input int n, output int dn, output int bz);
    dn = 0;
    bz = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (busy) bz++;
    end
  endtask

  initial begin
    exp_t e;
    int dn;
    int bz;
    logic [31:0] h0;
    logic [31:0] l0;

    tbl[0]  = '{8'h18, 32'hFFFFFFFD, 32'd7,
                32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    tbl[1]  = '{8'h19, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    tbl[2]  = '{8'h1A, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[3]  = '{8'h1B, 32'd7, 32'd2,
                32'd1, 32'd3, 1'b0, 33};
    tbl[4]  = '{8'h1A, 32'h80000000, 32'hFFFFFFFF,
                32'd0, 32'h80000000, 1'b0, 33};
    tbl[5]  = '{8'h1B, 32'd5, 32'd0,
                32'd5, 32'hFFFFFFFF, 1'b1, 0};
    tbl[6]  = '{8'h11, 32'h0000ABCD, 32'd9,
                32'h0000ABCD, 32'hFFFFFFFF, 1'b0, 0};
    tbl[7]  = '{8'h13, 32'h00001234, 32'd9,
                32'h0000ABCD, 32'h00001234, 1'b0, 0};
    tbl[8]  = '{8'h18, 32'h7FFFFFFF, 32'h80000000,
                32'hC0000000, 32'h80000000, 1'b0, 33};
    tbl[9]  = '{8'h1A, 32'd100, 32'hFFFFFFF9,
                32'd2, 32'hFFFFFFF2, 1'b0, 33};
    tbl[10] = '{8'h1B, 32'hFFFFFFFF, 32'd10,
                32'd5, 32'h19999999, 1'b0, 33};
    tbl[11] = '{8'h1A, 32'hFFFFFFFB, 32'd0,
                32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0};
    tbl[12] = '{8'h18, 32'd0, 32'h12345678,
                32'd0, 32'd0, 1'b0, 33};

    rst = 1'b1;
    start = 1'b0;
    select = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset dbz", 64'(div_by_zero), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      e = '{tbl[i].hi, tbl[i].lo, tbl[i].dbz, tbl[i].lat};
      run_op($sformatf("vec%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b,
             e, 0);
    end

    // DIV start at edge 5 of a MULT must be ignored.
    e = '{32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    run_op("mult with start while busy", 8'h18, 32'hFFFFFFFD, 32'd7,
           e, 5);
    idle_watch(40, dn, bz);
    check("no extra done after busy start", 64'(dn), 64'(0));
    check("no extra busy after busy start", 64'(bz), 64'(0));

    // Unknown selects, including a valid funct with upper bits set.
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    start = 1'b1;
    select = 8'h20;
    @(negedge clk);
    select = 8'h58;
    @(negedge clk);
    start = 1'b0;
    idle_watch(40, dn, bz);
    check("bad select done", 64'(dn), 64'(0));
    check("bad select busy", 64'(bz), 64'(0));
    check("bad select hi/lo", {hi, lo}, {h0, l0});

    // Reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1;
    select = 8'h1A;
    a = 32'd1000;
    b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy before reset", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("reset mid-op busy", 64'(busy), 64'(0));
    check("reset mid-op hi", 64'(hi), 64'(0));
    check("reset mid-op lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    idle_watch(40, dn, bz);
    check("no done after reset", 64'(dn), 64'(0));

    e = '{32'd0, 32'd15, 1'b0, 33};
    run_op("multu after reset", 8'h19, 32'd3, 32'd5, e, 0);

    check("scoreboard drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, the successor to the single-cycle combinational ALU in the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and handles MTHI/MTLO writes. A start/busy/done handshake lets the pipeline stall only on MFHI/MFLO hazards. `hi` and `lo` are always readable, so MFHI and MFLO need no unit cycle.

## Interface
- `BITS`, 32: operand and HI/LO width, ≥ 4.
- `OPTION_BITS`, 8: width of `select`; the MIPS funct code sits in bits [5:0], upper bits must be 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `select`  in  OPTION_BITS  operation: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
- `a`  in  BITS  multiplicand / dividend / MTHI-MTLO source.
- `b`  in  BITS  multiplier / divisor.
- `busy`  out  1  operation in progress; new starts are ignored.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `div_by_zero`  out  1  pulses with `done` when DIV/DIVU has `b == 0`.
- `hi`  out  BITS  HI register.
- `lo`  out  BITS  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset forces IDLE and sets `busy`, `done`, `div_by_zero`, `hi` and `lo` to 0. Reset mid-operation discards the operation.
- In IDLE with `start` = 1, behaviour depends on `select`:
  - MTHI / MTLO: write `a` into `hi` / `lo`. `done` pulses next cycle. State stays IDLE and `busy` stays 0.
  - MULT / DIV: latch `|a|` and `|b|` (two's-complement magnitude, BITS-bit unsigned) and the sign bits.
  - MULTU / DIVU: latch raw operands with sign flags 0.
  - Then load the counter with BITS, set `busy`, and go to MUL or DIV.
  - DIV / DIVU with `b == 0`: no iteration. Write `hi` = `a` and `lo` = all ones. `done` and `div_by_zero` pulse next cycle. State stays IDLE.
  - Any other `select`: ignored. No state change, no `done`.
- MUL does shift-add on a 2·BITS-bit accumulator {P, multiplier}:
  - If the multiplier LSB is 1, add the multiplicand into upper P using a BITS+1-bit sum, keeping the carry.
  - Shift the whole accumulator right by 1 and decrement the counter.
  - At count 0, go to FIX.
- DIV does restoring division:
  - Shift the {R, Q} accumulator left by 1 and trial-subtract the divisor from R using BITS+1 bits.
  - If the result is non-negative, keep it and set Q LSB = 1; otherwise restore and set Q LSB = 0.
  - Decrement the counter; at count 0, go to FIX.
- FIX (one cycle):
  - Product: negate the 2·BITS result if `sign_a ^ sign_b` (signed ops only), then `hi` = upper half and `lo` = lower half.
  - Quotient: goes to `lo`, negated if the signs differ.
  - Remainder: goes to `hi`, negated if `sign_a` (the remainder takes the dividend's sign).
  - Clear `busy`, pulse `done`, return to IDLE.
- DIV of most-negative by −1 yields `lo` = most-negative and `hi` = 0 (wraps, no trap).
- `hi` and `lo` never change during MUL/DIV; they update only at the FIX edge.
- `start` is ignored while `busy` = 1 and in the `done` cycle. A new start is accepted in the first IDLE cycle after `done`.

## Timing
- `start` is sampled at edge 0.
- MUL/DIV iterate on edges 1..BITS; FIX writes at edge BITS+1.
- `done` is high for exactly the one cycle after edge BITS+1, i.e. 33 edges after the start edge for BITS=32.
- `busy` is high from after edge 0 until edge BITS+1, and low in the `done` cycle.
- MTHI, MTLO and divide-by-zero complete in 1 edge: `done` is high in the cycle after edge 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Signed multiply:** MULT a=0xFFFFFFFD (−3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `done` high exactly 33 edges after start; `busy` high for 33 cycles.
- **Unsigned multiply:** MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Divides:**
  - DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU a=7, b=2 → `lo`=3, `hi`=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIVU a=5, b=0 → one edge later `done`=1, `div_by_zero`=1, `hi`=5, `lo`=0xFFFFFFFF, `busy` never asserted.
- **Busy and MTHI/MTLO:**
  - During MULT, assert `start` with DIV at edge 5 → ignored; the MULT result and latency are unchanged.
  - MTLO a=0x1234 → `lo`=0x1234 one edge later, `hi` unchanged.
- **Reset mid-operation:** assert `rst` at edge 10 of a DIV → `busy`=0, `hi`=`lo`=0 immediately, no `done`. A following MULTU 3×5 yields `lo`=15 with normal latency.
